// File: rtl/bank_wb_addr_router.sv
// rtl/bank_wb_addr_router.sv - delays per-channel index sets PIPE_LAT cycles, then routes each
// channel's memory address to the write port of its bank, with drain tracking and conflict flag.
`ifndef MA_width
`define MA_width 8
`endif
`ifndef BANK_width
`define BANK_width 4
`endif

module bank_wb_addr_router #(
  parameter int PIPE_LAT = 4,
  parameter int NCH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   BN_MA_out_en,
  input  logic [`MA_width-1:0]   MA0_idx,
  input  logic [`MA_width-1:0]   MA1_idx,
  input  logic [`MA_width-1:0]   MA2_idx,
  input  logic [`MA_width-1:0]   MA3_idx,
  input  logic [`MA_width-1:0]   MA4_idx,
  input  logic [`MA_width-1:0]   MA5_idx,
  input  logic [`MA_width-1:0]   MA6_idx,
  input  logic [`MA_width-1:0]   MA7_idx,
  input  logic [`MA_width-1:0]   MA8_idx,
  input  logic [`MA_width-1:0]   MA9_idx,
  input  logic [`MA_width-1:0]   MA10_idx,
  input  logic [`MA_width-1:0]   MA11_idx,
  input  logic [`MA_width-1:0]   MA12_idx,
  input  logic [`MA_width-1:0]   MA13_idx,
  input  logic [`MA_width-1:0]   MA14_idx,
  input  logic [`MA_width-1:0]   MA15_idx,
  input  logic [`BANK_width-1:0] BN0_idx,
  input  logic [`BANK_width-1:0] BN1_idx,
  input  logic [`BANK_width-1:0] BN2_idx,
  input  logic [`BANK_width-1:0] BN3_idx,
  input  logic [`BANK_width-1:0] BN4_idx,
  input  logic [`BANK_width-1:0] BN5_idx,
  input  logic [`BANK_width-1:0] BN6_idx,
  input  logic [`BANK_width-1:0] BN7_idx,
  input  logic [`BANK_width-1:0] BN8_idx,
  input  logic [`BANK_width-1:0] BN9_idx,
  input  logic [`BANK_width-1:0] BN10_idx,
  input  logic [`BANK_width-1:0] BN11_idx,
  input  logic [`BANK_width-1:0] BN12_idx,
  input  logic [`BANK_width-1:0] BN13_idx,
  input  logic [`BANK_width-1:0] BN14_idx,
  input  logic [`BANK_width-1:0] BN15_idx,
  input  logic                   LAST_STAGE,
  input  logic [2:0]             l_AGU_in,
  input  logic                   AGU_done_in,
  output logic [`MA_width-1:0]   WR_ADDR0,
  output logic [`MA_width-1:0]   WR_ADDR1,
  output logic [`MA_width-1:0]   WR_ADDR2,
  output logic [`MA_width-1:0]   WR_ADDR3,
  output logic [`MA_width-1:0]   WR_ADDR4,
  output logic [`MA_width-1:0]   WR_ADDR5,
  output logic [`MA_width-1:0]   WR_ADDR6,
  output logic [`MA_width-1:0]   WR_ADDR7,
  output logic [`MA_width-1:0]   WR_ADDR8,
  output logic [`MA_width-1:0]   WR_ADDR9,
  output logic [`MA_width-1:0]   WR_ADDR10,
  output logic [`MA_width-1:0]   WR_ADDR11,
  output logic [`MA_width-1:0]   WR_ADDR12,
  output logic [`MA_width-1:0]   WR_ADDR13,
  output logic [`MA_width-1:0]   WR_ADDR14,
  output logic [`MA_width-1:0]   WR_ADDR15,
  output logic [15:0]            WR_EN,
  output logic [2:0]             l_wb_out,
  output logic                   wb_busy,
  output logic                   wb_done,
  output logic                   bank_conflict
);
  localparam int MAW = `MA_width;
  localparam int BW  = `BANK_width;
  localparam int LP  = PIPE_LAT - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  logic [NCH-1:0][MAW-1:0] ma_in;
  logic [NCH-1:0][BW-1:0]  bn_in;

  assign ma_in = {MA15_idx, MA14_idx, MA13_idx, MA12_idx, MA11_idx, MA10_idx, MA9_idx, MA8_idx,
                  MA7_idx,  MA6_idx,  MA5_idx,  MA4_idx,  MA3_idx,  MA2_idx,  MA1_idx, MA0_idx};
  assign bn_in = {BN15_idx, BN14_idx, BN13_idx, BN12_idx, BN11_idx, BN10_idx, BN9_idx, BN8_idx,
                  BN7_idx,  BN6_idx,  BN5_idx,  BN4_idx,  BN3_idx,  BN2_idx,  BN1_idx, BN0_idx};

  // Tap 0 is the live input; tap k is the set captured k edges ago. The output registers
  // load from the last tap, which gives PIPE_LAT cycles from input to write port.
  logic                    tap_v    [PIPE_LAT];
  logic                    tap_last [PIPE_LAT];
  logic [2:0]              tap_tag  [PIPE_LAT];
  logic [NCH-1:0][MAW-1:0] tap_ma   [PIPE_LAT];
  logic [NCH-1:0][BW-1:0]  tap_bn   [PIPE_LAT];

  assign tap_v[0]    = BN_MA_out_en;
  assign tap_last[0] = LAST_STAGE;
  assign tap_tag[0]  = l_AGU_in;
  assign tap_ma[0]   = ma_in;
  assign tap_bn[0]   = bn_in;

  for (genvar k = 1; k < PIPE_LAT; k++) begin : g_stage
    logic                    v_q;
    logic                    last_q;
    logic [2:0]              tag_q;
    logic [NCH-1:0][MAW-1:0] ma_q;
    logic [NCH-1:0][BW-1:0]  bn_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) v_q <= 1'b0;
      else      v_q <= tap_v[k-1];
    end

    always_ff @(posedge clk) begin
      last_q <= tap_last[k-1];
      tag_q  <= tap_tag[k-1];
      ma_q   <= tap_ma[k-1];
      bn_q   <= tap_bn[k-1];
    end

    assign tap_v[k]    = v_q;
    assign tap_last[k] = last_q;
    assign tap_tag[k]  = tag_q;
    assign tap_ma[k]   = ma_q;
    assign tap_bn[k]   = bn_q;
  end

  logic line_busy;
  always_comb begin
    line_busy = 1'b0;
    for (int k = 0; k < PIPE_LAT; k++) line_busy = line_busy | tap_v[k];
  end

  // Ascending scan: the first channel to claim a bank keeps it, later claimants flag a conflict.
  logic [NCH-1:0]          route_en;
  logic [NCH-1:0][MAW-1:0] route_addr;
  logic                    route_conf;
  always_comb begin
    route_en   = '0;
    route_addr = '0;
    route_conf = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (c < 2 || !tap_last[LP]) begin
        if (route_en[tap_bn[LP][c]]) begin
          route_conf = 1'b1;
        end else begin
          route_en[tap_bn[LP][c]]   = 1'b1;
          route_addr[tap_bn[LP][c]] = tap_ma[LP][c];
        end
      end
    end
  end

  logic [NCH-1:0]          wr_en_q, wr_en_d;
  logic [NCH-1:0][MAW-1:0] wr_addr_q, wr_addr_d;
  logic [2:0]              l_wb_q, l_wb_d;
  logic                    conflict_q, conflict_d;

  always_comb begin
    wr_en_d    = '0;
    wr_addr_d  = '0;
    l_wb_d     = '0;
    conflict_d = conflict_q;
    if (tap_v[LP]) begin
      wr_en_d    = route_en;
      wr_addr_d  = route_addr;
      l_wb_d     = tap_tag[LP];
      conflict_d = conflict_q | route_conf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      l_wb_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      l_wb_q     <= l_wb_d;
      conflict_q <= conflict_d;
    end
  end

  state_t state_q, state_d;
  logic   done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Drain ends once nothing is left to write, counting a set captured on this same edge.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (AGU_done_in)       state_d = ST_DRAIN;
        else if (BN_MA_out_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (AGU_done_in) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!line_busy) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign WR_EN         = wr_en_q;
  assign l_wb_out      = l_wb_q;
  assign wb_busy       = (state_q != ST_IDLE);
  assign wb_done       = done_q;
  assign bank_conflict = conflict_q;

  assign WR_ADDR0  = wr_addr_q[0];
  assign WR_ADDR1  = wr_addr_q[1];
  assign WR_ADDR2  = wr_addr_q[2];
  assign WR_ADDR3  = wr_addr_q[3];
  assign WR_ADDR4  = wr_addr_q[4];
  assign WR_ADDR5  = wr_addr_q[5];
  assign WR_ADDR6  = wr_addr_q[6];
  assign WR_ADDR7  = wr_addr_q[7];
  assign WR_ADDR8  = wr_addr_q[8];
  assign WR_ADDR9  = wr_addr_q[9];
  assign WR_ADDR10 = wr_addr_q[10];
  assign WR_ADDR11 = wr_addr_q[11];
  assign WR_ADDR12 = wr_addr_q[12];
  assign WR_ADDR13 = wr_addr_q[13];
  assign WR_ADDR14 = wr_addr_q[14];
  assign WR_ADDR15 = wr_addr_q[15];
endmodule
